// File: rtl/riscv_pkg.sv
// Shared RV32 constants and the static branch-prediction rule used by the IF/ID stage.
package riscv_pkg;

  localparam int unsigned XLEN_DEF = 32;

  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // JAL is always taken. A B-type branch is taken only when it is backward
  // (sign bit set) and BTFN is enabled. JALR is resolved in EX.
  function automatic logic predecode_taken(input logic [31:0] instr, input bit btfn);
    logic taken;
    taken = 1'b0;
    case (instr[6:0])
      OPC_JAL:    taken = 1'b1;
      OPC_BRANCH: taken = btfn & instr[31];
      OPC_JALR:   taken = 1'b0;
      default:    taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/if_id_stage_if.sv
// Fetch-side and decode-side signals of the IF/ID slot. The stage uses the
// slave view; the fetch/decode environment uses the master view.
interface if_id_stage_if #(
  parameter int unsigned XLEN = riscv_pkg::XLEN_DEF
);
  // fetch side
  logic [XLEN-1:0] if_instruction;
  logic [XLEN-1:0] if_pc;
  logic            stall;
  logic            pc_src;
  logic [XLEN-1:0] branch_target;
  // decode side
  logic            id_valid;
  logic [XLEN-1:0] id_instruction;
  logic [XLEN-1:0] id_pc;
  logic            id_pred_taken;
  logic            id_ready;

  modport slave (
    input  if_instruction, if_pc, id_ready,
    output stall, pc_src, branch_target,
    output id_valid, id_instruction, id_pc, id_pred_taken
  );

  modport master (
    output if_instruction, if_pc, id_ready,
    input  stall, pc_src, branch_target,
    input  id_valid, id_instruction, id_pc, id_pred_taken
  );
endinterface

// File: rtl/early_predecode.sv
// Combinational predecode of the instruction held in the IF/ID slot:
// decides whether to redirect early and computes the PC-relative target.
module early_predecode
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN         = XLEN_DEF,
  parameter bit          PREDICT_BTFN = 1'b1
) (
  input  logic [XLEN-1:0] instr,
  input  logic [XLEN-1:0] pc,
  output logic            taken,
  output logic [XLEN-1:0] target
);

  logic [XLEN-1:0] imm_j;
  logic [XLEN-1:0] imm_b;
  logic [XLEN-1:0] imm;

  assign imm_j = {{(XLEN-20){instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
  assign imm_b = {{(XLEN-12){instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};

  // Select the immediate by format and form the wrap-around target.
  always_comb begin
    taken  = predecode_taken(instr[31:0], PREDICT_BTFN);
    imm    = (instr[6:0] == OPC_JAL) ? imm_j : imm_b;
    target = pc + imm;
  end

endmodule

// File: rtl/if_id_stage.sv
// IF/ID pipeline slot: registers fetch output, hands it to decode with a
// valid/ready handshake, and steers fetch (stall / early redirect / EX flush).
module if_id_stage
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN         = XLEN_DEF,
  parameter bit          PREDICT_BTFN = 1'b1,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  if_id_stage_if.slave     bus,
  input  logic             ex_redirect,
  input  logic [XLEN-1:0]  ex_target,
  output logic [CNT_W-1:0] bubble_count
);

  logic             valid_q, valid_d;
  logic [XLEN-1:0]  instr_q, instr_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic             pred_q, pred_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             pd_taken;
  logic [XLEN-1:0]  pd_target;
  logic             fire;
  logic             early;
  logic             load_en;
  logic             flush;

  // Predecode looks at the registered slot only, never at the fetch bus.
  early_predecode #(
    .XLEN         (XLEN),
    .PREDICT_BTFN (PREDICT_BTFN)
  ) u_predecode (
    .instr  (instr_q),
    .pc     (pc_q),
    .taken  (pd_taken),
    .target (pd_target)
  );

  // Handshake, stall and redirect mux; EX redirect beats the early redirect.
  always_comb begin
    fire    = valid_q & bus.id_ready;
    early   = fire & pd_taken;
    load_en = ~valid_q | bus.id_ready | ex_redirect;
    flush   = ex_redirect | early;

    bus.stall         = valid_q & ~bus.id_ready & ~ex_redirect;
    bus.pc_src        = flush;
    bus.branch_target = '0;
    if (ex_redirect) begin
      bus.branch_target = ex_target;
    end else if (early) begin
      bus.branch_target = pd_target;
    end

    bus.id_valid       = valid_q;
    bus.id_instruction = instr_q;
    bus.id_pc          = pc_q;
    bus.id_pred_taken  = pred_q;
    bubble_count       = cnt_q;
  end

  // Slot next state: a redirect loads a bubble (the fetched word is wrong-path),
  // otherwise the slot takes the fetch word whenever it is free or consumed.
  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    pred_d  = pred_q;
    cnt_d   = cnt_q;
    if (flush) begin
      valid_d = 1'b0;
      instr_d = XLEN'(NOP_INSTR);
      pred_d  = 1'b0;
      if (cnt_q != '1) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else if (load_en) begin
      valid_d = 1'b1;
      instr_d = bus.if_instruction;
      pc_d    = bus.if_pc;
      pred_d  = predecode_taken(bus.if_instruction[31:0], PREDICT_BTFN);
    end
  end

  // Slot and counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      instr_q <= XLEN'(NOP_INSTR);
      pc_q    <= '0;
      pred_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
      pred_q  <= pred_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_if_id_stage.sv
// Directed bench for if_id_stage: one BTFN-enabled instance and one with
// BTFN disabled, fed the same fetch stream.
module tb_if_id_stage;

  localparam logic [31:0] ADDI = 32'h0010_0093;
  localparam logic [31:0] JAL  = 32'h0200_006F;  // jal x0, +0x20
  localparam logic [31:0] BEQB = 32'hFE00_0CE3;  // beq, -8
  localparam logic [31:0] BEQF = 32'h0000_0863;  // beq, +16
  localparam logic [31:0] NOP  = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        ex_redirect;
  logic [31:0] ex_target;
  logic [15:0] bc0;
  logic [15:0] bc1;

  int n_tests;
  int n_fail;

  if_id_stage_if #(.XLEN(32)) if0 ();
  if_id_stage_if #(.XLEN(32)) if1 ();

  assign if1.if_instruction = if0.if_instruction;
  assign if1.if_pc          = if0.if_pc;
  assign if1.id_ready       = if0.id_ready;

  if_id_stage #(.XLEN(32), .PREDICT_BTFN(1'b1), .CNT_W(16)) dut0 (
    .clk          (clk),
    .rst          (rst),
    .bus          (if0),
    .ex_redirect  (ex_redirect),
    .ex_target    (ex_target),
    .bubble_count (bc0)
  );

  if_id_stage #(.XLEN(32), .PREDICT_BTFN(1'b0), .CNT_W(16)) dut1 (
    .clk          (clk),
    .rst          (rst),
    .bus          (if1),
    .ex_redirect  (ex_redirect),
    .ex_target    (ex_target),
    .bubble_count (bc1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    ex_redirect = 1'b0;
    ex_target = '0;
    if0.id_ready = 1'b1;
    if0.if_pc = 32'h0;
    if0.if_instruction = ADDI;
    step();
    step();
    rst = 1'b1;
    step();
    n_tests++;
    if (if0.id_valid !== 1'b1) begin
      n_fail++; $display("FAIL reset_release_valid: got %b want 1", if0.id_valid);
    end
    if0.id_ready = 1'b0;
    #1;
    n_tests++;
    if (if0.stall !== 1'b1) begin
      n_fail++; $display("FAIL pre_reset_stall: got %b want 1", if0.stall);
    end
    rst = 1'b0;
    #1;
    n_tests++;
    if (if0.id_valid !== 1'b0 || if0.stall !== 1'b0 || if0.pc_src !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset_ctrl: valid=%b stall=%b pc_src=%b want 0 0 0",
               if0.id_valid, if0.stall, if0.pc_src);
    end
    n_tests++;
    if (if0.id_instruction !== NOP || if0.id_pc !== 32'h0 || if0.id_pred_taken !== 1'b0 ||
        bc0 !== 16'd0) begin
      n_fail++;
      $display("FAIL async_reset_regs: instr=%h pc=%h pred=%b bc=%0d want %h 0 0 0",
               if0.id_instruction, if0.id_pc, if0.id_pred_taken, bc0, NOP);
    end
  endtask

  task automatic test_stream;
    if0.id_ready = 1'b1;
    rst = 1'b1;
    if0.if_pc = 32'h0;
    if0.if_instruction = ADDI;
    for (int i = 0; i < 3; i++) begin
      step();
      if0.if_pc = 32'(4 * (i + 1));
      n_tests++;
      if (if0.id_valid !== 1'b1 || if0.id_pc !== 32'(4 * i) || if0.stall !== 1'b0 ||
          if0.pc_src !== 1'b0) begin
        n_fail++;
        $display("FAIL stream_%0d: valid=%b pc=%h stall=%b pc_src=%b want 1 %h 0 0",
                 i, if0.id_valid, if0.id_pc, if0.stall, if0.pc_src, 32'(4 * i));
      end
    end
    n_tests++;
    if (bc0 !== 16'd0) begin
      n_fail++; $display("FAIL stream_bubbles: got %0d want 0", bc0);
    end
  endtask

  task automatic test_jal;
    if0.if_pc = 32'h10;
    if0.if_instruction = JAL;
    step();
    n_tests++;
    if (if0.pc_src !== 1'b1 || if0.branch_target !== 32'h30 || if0.id_pred_taken !== 1'b1) begin
      n_fail++;
      $display("FAIL jal_redirect: pc_src=%b tgt=%h pred=%b want 1 00000030 1",
               if0.pc_src, if0.branch_target, if0.id_pred_taken);
    end
    if0.if_pc = 32'h14;
    if0.if_instruction = ADDI;
    step();
    n_tests++;
    if (if0.id_valid !== 1'b0 || if0.pc_src !== 1'b0 || if0.branch_target !== 32'h0 ||
        bc0 !== 16'd1) begin
      n_fail++;
      $display("FAIL jal_bubble: valid=%b pc_src=%b tgt=%h bc=%0d want 0 0 0 1",
               if0.id_valid, if0.pc_src, if0.branch_target, bc0);
    end
    if0.if_pc = 32'h30;
    step();
    n_tests++;
    if (if0.id_valid !== 1'b1 || if0.id_pc !== 32'h30) begin
      n_fail++;
      $display("FAIL jal_target_slot: valid=%b pc=%h want 1 00000030", if0.id_valid, if0.id_pc);
    end
  endtask

  task automatic test_btfn;
    if0.if_pc = 32'h20;
    if0.if_instruction = BEQB;
    step();
    n_tests++;
    if (if0.pc_src !== 1'b1 || if0.branch_target !== 32'h18 || if0.id_pred_taken !== 1'b1) begin
      n_fail++;
      $display("FAIL btfn_back_taken: pc_src=%b tgt=%h pred=%b want 1 00000018 1",
               if0.pc_src, if0.branch_target, if0.id_pred_taken);
    end
    n_tests++;
    if (if1.id_valid !== 1'b1 || if1.pc_src !== 1'b0 || if1.id_pred_taken !== 1'b0) begin
      n_fail++;
      $display("FAIL nobtfn_back: valid=%b pc_src=%b pred=%b want 1 0 0",
               if1.id_valid, if1.pc_src, if1.id_pred_taken);
    end
    if0.if_pc = 32'h24;
    if0.if_instruction = ADDI;
    step();
    n_tests++;
    if (if0.id_valid !== 1'b0 || bc0 !== 16'd2) begin
      n_fail++; $display("FAIL btfn_bubble: valid=%b bc=%0d want 0 2", if0.id_valid, bc0);
    end
    n_tests++;
    if (if1.id_valid !== 1'b1 || if1.id_pc !== 32'h24 || bc1 !== 16'd1) begin
      n_fail++;
      $display("FAIL nobtfn_fallthrough: valid=%b pc=%h bc=%0d want 1 00000024 1",
               if1.id_valid, if1.id_pc, bc1);
    end
    if0.if_pc = 32'h18;
    if0.if_instruction = BEQF;
    step();
    n_tests++;
    if (if0.id_valid !== 1'b1 || if0.pc_src !== 1'b0 || if0.id_pred_taken !== 1'b0 ||
        if1.pc_src !== 1'b0) begin
      n_fail++;
      $display("FAIL fwd_branch: valid=%b pc_src=%b pred=%b pc_src1=%b want 1 0 0 0",
               if0.id_valid, if0.pc_src, if0.id_pred_taken, if1.pc_src);
    end
  endtask

  task automatic test_stall;
    if0.if_pc = 32'h40;
    if0.if_instruction = JAL;
    step();
    if0.id_ready = 1'b0;
    if0.if_pc = 32'h44;
    if0.if_instruction = ADDI;
    #1;
    for (int i = 0; i < 3; i++) begin
      if (i != 0) step();
      n_tests++;
      if (if0.stall !== 1'b1 || if0.pc_src !== 1'b0 || if0.id_pc !== 32'h40 ||
          if0.id_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL stall_hold_%0d: stall=%b pc_src=%b pc=%h valid=%b want 1 0 00000040 1",
                 i, if0.stall, if0.pc_src, if0.id_pc, if0.id_valid);
      end
    end
    if0.id_ready = 1'b1;
    #1;
    n_tests++;
    if (if0.pc_src !== 1'b1 || if0.branch_target !== 32'h60 || if0.stall !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_release: pc_src=%b tgt=%h stall=%b want 1 00000060 0",
               if0.pc_src, if0.branch_target, if0.stall);
    end
    step();
    n_tests++;
    if (if0.id_valid !== 1'b0 || if0.pc_src !== 1'b0 || bc0 !== 16'd3) begin
      n_fail++;
      $display("FAIL stall_bubble: valid=%b pc_src=%b bc=%0d want 0 0 3",
               if0.id_valid, if0.pc_src, bc0);
    end
    if0.if_pc = 32'h60;
    step();
    n_tests++;
    if (if0.id_valid !== 1'b1 || if0.id_pc !== 32'h60 || if0.pc_src !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_target_slot: valid=%b pc=%h pc_src=%b want 1 00000060 0",
               if0.id_valid, if0.id_pc, if0.pc_src);
    end
  endtask

  task automatic test_ex_redirect;
    if0.if_pc = 32'h70;
    if0.if_instruction = JAL;
    step();
    ex_redirect = 1'b1;
    ex_target = 32'h100;
    #1;
    n_tests++;
    if (if0.pc_src !== 1'b1 || if0.branch_target !== 32'h100) begin
      n_fail++;
      $display("FAIL ex_over_early: pc_src=%b tgt=%h want 1 00000100",
               if0.pc_src, if0.branch_target);
    end
    if0.if_pc = 32'h74;
    if0.if_instruction = ADDI;
    step();
    ex_redirect = 1'b0;
    #1;
    n_tests++;
    if (if0.id_valid !== 1'b0 || bc0 !== 16'd4) begin
      n_fail++; $display("FAIL ex_flush_once: valid=%b bc=%0d want 0 4", if0.id_valid, bc0);
    end
    if0.if_pc = 32'h100;
    step();
    if0.id_ready = 1'b0;
    #1;
    n_tests++;
    if (if0.id_valid !== 1'b1 || if0.stall !== 1'b1) begin
      n_fail++; $display("FAIL ex_pre_stall: valid=%b stall=%b want 1 1", if0.id_valid, if0.stall);
    end
    ex_redirect = 1'b1;
    ex_target = 32'h200;
    #1;
    n_tests++;
    if (if0.stall !== 1'b0 || if0.pc_src !== 1'b1 || if0.branch_target !== 32'h200) begin
      n_fail++;
      $display("FAIL ex_during_stall: stall=%b pc_src=%b tgt=%h want 0 1 00000200",
               if0.stall, if0.pc_src, if0.branch_target);
    end
    step();
    ex_redirect = 1'b0;
    if0.id_ready = 1'b1;
    #1;
    n_tests++;
    if (if0.id_valid !== 1'b0 || bc0 !== 16'd5 || if0.pc_src !== 1'b0 ||
        if0.branch_target !== 32'h0) begin
      n_fail++;
      $display("FAIL ex_stall_flush: valid=%b bc=%0d pc_src=%b tgt=%h want 0 5 0 0",
               if0.id_valid, bc0, if0.pc_src, if0.branch_target);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail = 0;
    test_reset();
    test_stream();
    test_jal();
    test_btfn();
    test_stall();
    test_ex_redirect();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
